rc4_prga_decrypt: RTL

- RC4 pseudo-random generation and decrypt stage; sits directly downstream of the key-scheduling FSM.
- Consumes the S array left in s_memory by key scheduling, reads the encrypted-message ROM, XORs the keystream with it, and writes plaintext to the decrypted-message RAM.
- Drives the S-memory port only while busy. The top level muxes the S port between key scheduling and this block using busy.

---
 rtl/rc4_prga_decrypt.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decrypt stage: walks the S array left by key scheduling,
// XORs the keystream with the encrypted ROM and writes plaintext. Optional: RC4_PLAINTEXT_CHECK_EN.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              key_invalid,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, LT_SI, WT_SJ, LT_SJ, WR_SJ, RD_F, WT_F, WR_DEC, DONE
  } state_t;

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] ONE_K  = MSG_AW'(1);

  state_t            state_reg;
  logic [7:0]        i_reg, j_reg, si_reg, sj_reg, enc_byte_reg;
  logic [MSG_AW-1:0] k_reg;
  logic              busy_reg, done_reg;
  logic [7:0]        s_addr_reg, s_wdata_reg;
  logic              s_wren_reg;
  logic [MSG_AW-1:0] enc_addr_reg, dec_addr_reg;
  logic [7:0]        dec_wdata_reg;
  logic              dec_wren_reg;
  logic              finish_byte;

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic key_invalid_reg;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
  endfunction

  assign key_invalid = key_invalid_reg;
  // A non-text byte means the key is wrong, so stop after writing it.
  assign finish_byte = (k_reg == LAST_K) || !is_text(dec_wdata_reg);
`else
  assign key_invalid = 1'b0;
  assign finish_byte = (k_reg == LAST_K);
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign s_addr    = s_addr_reg;
  assign s_wdata   = s_wdata_reg;
  assign s_wren    = s_wren_reg;
  assign enc_addr  = enc_addr_reg;
  assign dec_addr  = dec_addr_reg;
  assign dec_wdata = dec_wdata_reg;
  assign dec_wren  = dec_wren_reg;

  // Outputs are registered: each transition loads the values the next state presents.
  // Values derived from s_q are captured one cycle early, while the read data is already stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      i_reg         <= 8'd0;
      j_reg         <= 8'd0;
      k_reg         <= '0;
      si_reg        <= 8'd0;
      sj_reg        <= 8'd0;
      enc_byte_reg  <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      s_addr_reg    <= 8'd0;
      s_wdata_reg   <= 8'd0;
      s_wren_reg    <= 1'b0;
      enc_addr_reg  <= '0;
      dec_addr_reg  <= '0;
      dec_wdata_reg <= 8'd0;
      dec_wren_reg  <= 1'b0;
`ifdef RC4_PLAINTEXT_CHECK_EN
      key_invalid_reg <= 1'b0;
`endif
    end else begin
      s_wren_reg   <= 1'b0;
      dec_wren_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            i_reg        <= 8'd0;
            j_reg        <= 8'd0;
            k_reg        <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b1;
            s_addr_reg   <= 8'd1;
            s_wdata_reg  <= 8'd0;
            enc_addr_reg <= '0;
            state_reg    <= RD_SI;
`ifdef RC4_PLAINTEXT_CHECK_EN
            key_invalid_reg <= 1'b0;
`endif
          end
        end
        RD_SI: begin
          i_reg     <= i_reg + 8'd1;
          state_reg <= WT_SI;
        end
        WT_SI: begin
          s_addr_reg <= j_reg + s_q;
          state_reg  <= LT_SI;
        end
        LT_SI: begin
          si_reg       <= s_q;
          enc_byte_reg <= enc_q;
          j_reg        <= j_reg + s_q;
          state_reg    <= WT_SJ;
        end
        WT_SJ: begin
          s_addr_reg  <= i_reg;
          s_wdata_reg <= s_q;
          s_wren_reg  <= 1'b1;
          state_reg   <= LT_SJ;
        end
        LT_SJ: begin
          sj_reg      <= s_q;
          s_addr_reg  <= j_reg;
          s_wdata_reg <= si_reg;
          s_wren_reg  <= 1'b1;
          state_reg   <= WR_SJ;
        end
        WR_SJ: begin
          s_addr_reg  <= si_reg + sj_reg;
          s_wdata_reg <= 8'd0;
          state_reg   <= RD_F;
        end
        RD_F: begin
          state_reg <= WT_F;
        end
        WT_F: begin
          dec_addr_reg  <= k_reg;
          dec_wdata_reg <= s_q ^ enc_byte_reg;
          dec_wren_reg  <= 1'b1;
          state_reg     <= WR_DEC;
        end
        WR_DEC: begin
          if (finish_byte) begin
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            s_addr_reg  <= 8'd0;
            s_wdata_reg <= 8'd0;
            state_reg   <= DONE;
`ifdef RC4_PLAINTEXT_CHECK_EN
            key_invalid_reg <= !is_text(dec_wdata_reg);
`endif
          end else begin
            k_reg        <= k_reg + ONE_K;
            enc_addr_reg <= k_reg + ONE_K;
            s_addr_reg   <= i_reg + 8'd1;
            state_reg    <= RD_SI;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
